instr_sequencer: RTL and testbench

- Instruction fetch/issue stage that sits directly upstream of the register-file/ALU datapath.
- Holds a small writable instruction memory and steps a program counter through it.
- Presents one registered 14-bit instruction per cycle in the datapath's format: [13:12] alu_control, [11:8] dest, [7:4] src1, [3:0] src2.
- Handles program load, start/done sequencing, and downstream stall.

---
 rtl/instr_sequencer.sv | 82 ++++++++
 tb/tb_instr_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: imem-backed fetch/issue stage feeding the ALU datapath one registered instruction per cycle.
// Optional dependency bubble insertion is enabled by defining INSTR_SEQ_HAZARD_STALL_EN.
module instr_sequencer #(
   parameter int          ADDR_W    = 4,
   parameter logic [13:0] NOP_INSTR = 14'h2000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [13:0]       load_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   input  logic              stall_in,
   output logic [13:0]       instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done
);
   localparam int            DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, BUBBLE, DONE} state_e;
   state_e            state_q, state_d;
   logic [13:0]       imem_q [DEPTH];
   logic [13:0]       instr_q, instr_d, rd;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] pc_q, pc_d, cnt_q, cnt_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              idle_like, accept, go, hazard, issue, last;
   assign idle_like = state_q == IDLE || state_q == DONE;
   assign accept    = idle_like && start;
   assign go        = accept && prog_len != '0;
   assign rd        = imem_q[pc_q];
`ifdef INSTR_SEQ_HAZARD_STALL_EN
   // the register file writes back one edge late, so a consumer directly behind its producer needs a gap
   assign hazard = valid_q && (rd[7:4] == instr_q[11:8] || rd[3:0] == instr_q[11:8]);
`else
   assign hazard = 1'b0;
`endif
   assign issue = !stall_in && ((state_q == RUN && !hazard) || state_q == BUBBLE);
   assign last  = {1'b0, cnt_q} == len_q - 1'b1;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         pc_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end
   // imem deliberately has no reset so a loaded program survives it
   always_ff @(posedge clk) begin
      if (!reset && load_en && idle_like) imem_q[load_addr] <= load_data;
   end
   always_comb begin
      state_d = state_q;
      if (accept) state_d = go ? RUN : DONE;
      else if (issue) state_d = last ? DONE : RUN;
      else if (state_q == RUN && !stall_in && hazard) state_d = BUBBLE;
   end
   always_comb begin
      instr_d = issue ? rd : NOP_INSTR;
      valid_d = issue;
      pc_d    = go ? '0 : issue ? pc_q + 1'b1 : pc_q;
      cnt_d   = go ? '0 : issue ? cnt_q + 1'b1 : cnt_q;
      len_d   = go ? (prog_len > MAX_LEN ? MAX_LEN : prog_len) : len_q;
   end
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign busy        = state_q == RUN || state_q == BUBBLE;
   assign done        = state_q == DONE;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed programs; expected issues are queued up front and a monitor pops them on each valid output.
module tb_instr_sequencer;
   localparam logic [13:0] NOP = 14'h2000;
   typedef struct { logic [13:0] instr; logic [3:0] pc; } exp_t;
   logic        clk = 0, reset = 1, load_en = 0, start = 0, stall_in = 0;
   logic [3:0]  load_addr = '0;
   logic [13:0] load_data = '0;
   logic [4:0]  prog_len = '0;
   logic [13:0] instr;
   logic        instr_valid, busy, done;
   logic [3:0]  pc;
   exp_t        q[$];
   int          tests = 0, fails = 0, nvalid = 0;
   logic        mon_en = 0;

   instr_sequencer dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .prog_len(prog_len), .start(start), .stall_in(stall_in), .instr(instr),
      .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (instr_valid) begin
            nvalid++;
            if (q.size() == 0) check("unexpected_valid", {18'h0, instr}, {18'h0, NOP});
            else begin
               exp_t e;
               e = q.pop_front();
               check("issue_instr", {18'h0, instr}, {18'h0, e.instr});
               check("issue_pc", {28'h0, pc}, {28'h0, e.pc});
            end
         end else check("filler_nop", {18'h0, instr}, {18'h0, NOP});
      end
   end

   task automatic load(input logic [3:0] a, input logic [13:0] d);
      load_en = 1; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 0;
   endtask

   task automatic push(input logic [13:0] i, input logic [3:0] p);
      exp_t e;
      e.instr = i; e.pc = p;
      q.push_back(e);
   endtask

   task automatic do_start(input logic [4:0] len);
      nvalid = 0; prog_len = len; start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic finish_run(input string name, input int n);
      int i;
      for (i = 0; i < 40 && !done; i++) @(negedge clk);
      check({name, "_done"}, {31'h0, done}, 32'h1);
      @(negedge clk);
      check({name, "_nop"}, {18'h0, instr}, {18'h0, NOP});
      check({name, "_done_hold"}, {31'h0, done}, 32'h1);
      check({name, "_count"}, nvalid, n);
      check({name, "_drained"}, q.size(), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_instr", {18'h0, instr}, {18'h0, NOP});
      check("rst_valid", {31'h0, instr_valid}, 0);
      check("rst_pc", {28'h0, pc}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      check("rst_done", {31'h0, done}, 0);
      reset = 0; mon_en = 1;
      load(0, 14'h0312); load(1, 14'h1567); load(2, 14'h389A);
      // basic 3-instruction program
      push(14'h0312, 1); push(14'h1567, 2); push(14'h389A, 3);
      do_start(3);
      check("run_busy", {31'h0, busy}, 1);
      check("run_first_latency", {31'h0, instr_valid}, 0);
      finish_run("basic", 3);
      check("basic_pc", {28'h0, pc}, 3);
      // downstream stall after first issue
      push(14'h0312, 1); push(14'h1567, 2); push(14'h389A, 3);
      do_start(3);
      @(negedge clk);
      stall_in = 1;
      repeat (2) begin
         @(negedge clk);
         check("stall_valid", {31'h0, instr_valid}, 0);
         check("stall_pc", {28'h0, pc}, 1);
      end
      stall_in = 0;
      finish_run("stall", 3);
      // zero-length program
      do_start(0);
      check("zero_done", {31'h0, done}, 1);
      check("zero_busy", {31'h0, busy}, 0);
      @(negedge clk);
      check("zero_count", nvalid, 0);
      // dependent back-to-back pair
      load(1, 14'h0434);
      push(14'h0312, 1); push(14'h0434, 2);
      do_start(2);
      @(negedge clk);
      check("dep_v0", {31'h0, instr_valid}, 1);
      @(negedge clk);
`ifdef INSTR_SEQ_HAZARD_STALL_EN
      check("dep_v1_bubble", {31'h0, instr_valid}, 0);
      check("dep_bubble_pc", {28'h0, pc}, 1);
      @(negedge clk);
      check("dep_v2", {31'h0, instr_valid}, 1);
`else
      check("dep_v1", {31'h0, instr_valid}, 1);
`endif
      finish_run("dep", 2);
      // reset in the middle of a run
      load(1, 14'h1567);
      push(14'h0312, 1); push(14'h1567, 2);
      do_start(3);
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("mid_rst_valid", {31'h0, instr_valid}, 0);
      check("mid_rst_busy", {31'h0, busy}, 0);
      check("mid_rst_pc", {28'h0, pc}, 0);
      check("mid_rst_instr", {18'h0, instr}, {18'h0, NOP});
      check("mid_rst_done", {31'h0, done}, 0);
      repeat (3) @(negedge clk);
      check("mid_rst_idle", {31'h0, busy}, 0);
      check("mid_rst_drained", nvalid, 2);
      // load attempt while running must be ignored, then rerun
      push(14'h0312, 1); push(14'h1567, 2); push(14'h389A, 3);
      do_start(3);
      load(1, 14'h3FFF);
      finish_run("run_load", 3);
      push(14'h0312, 1); push(14'h1567, 2); push(14'h389A, 3);
      do_start(3);
      finish_run("rerun", 3);
      // full-depth program with wrap, address 0 written together with start
      for (int i = 1; i < 16; i++) load(4'(i), {2'(i), 4'(i), 4'(i), 4'(i)});
      for (int i = 0; i < 16; i++) push({2'(i), 4'(i), 4'(i), 4'(i)}, 4'(i + 1));
      load_en = 1; load_addr = 0; load_data = 14'h0000;
      do_start(16);
      load_en = 0;
      finish_run("wrap16", 16);
      check("wrap16_pc", {28'h0, pc}, 0);
      for (int i = 0; i < 16; i++) push({2'(i), 4'(i), 4'(i), 4'(i)}, 4'(i + 1));
      do_start(20);
      finish_run("clamp20", 16);
      check("clamp20_pc", {28'h0, pc}, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
